// File: rtl/display_scan_ctrl.sv
// Scan scheduler for the two shared 7-segment buses: alternating digit phases, anti-ghost blanking, per-digit blink.
// Optional DISP_SCAN_BLANK_EN compiles in the blank interval at the start of each phase.
module display_scan_ctrl #(
    parameter int REFRESH_DIV  = 8192,
    parameter int BLANK_CYC    = 64,
    parameter int BLINK_FRAMES = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] seg0,
    input  logic [6:0] seg1,
    input  logic [6:0] seg2,
    input  logic [6:0] seg3,
    input  logic [3:0] blink_mask,
    input  logic       disp_en,
    output logic       sel,
    output logic [6:0] seg_a,
    output logic [6:0] seg_b,
    output logic       frame_tick
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CW-1:0] CNT_LAST   = CW'(REFRESH_DIV - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

    typedef enum logic [1:0] {
        P0_BLANK,
        P0_SHOW,
        P1_BLANK,
        P1_SHOW
    } state_t;

`ifdef DISP_SCAN_BLANK_EN
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
    localparam state_t RESET_STATE = P0_BLANK;
`else
    localparam state_t RESET_STATE = P0_SHOW;
    // Blank interval is compiled out; BLANK_CYC stays only so both builds share one parameter list.
    if (BLANK_CYC < 0) begin : g_blank_cyc_unused
    end
`endif

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            init_q, init_d;
    logic [3:0][6:0] shadow_q, shadow_d;
    logic [3:0]      mask_q, mask_d;
    logic [FW-1:0]   fcnt_q, fcnt_d;
    logic            blink_ph_q, blink_ph_d;
    logic            sel_q, sel_d;
    logic [6:0]      seg_a_q, seg_a_d;
    logic [6:0]      seg_b_q, seg_b_d;
    logic            frame_tick_q, frame_tick_d;
    logic            frame_edge;
    logic [3:0][6:0] code;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= RESET_STATE;
            cnt_q        <= '0;
            init_q       <= 1'b1;
            shadow_q     <= '0;
            mask_q       <= '0;
            fcnt_q       <= '0;
            blink_ph_q   <= 1'b0;
            sel_q        <= 1'b0;
            seg_a_q      <= '0;
            seg_b_q      <= '0;
            frame_tick_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            init_q       <= init_d;
            shadow_q     <= shadow_d;
            mask_q       <= mask_d;
            fcnt_q       <= fcnt_d;
            blink_ph_q   <= blink_ph_d;
            sel_q        <= sel_d;
            seg_a_q      <= seg_a_d;
            seg_b_q      <= seg_b_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    // cnt spans the whole phase (blank + show); it is cleared only when the phase flips.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + CW'(1);
        frame_edge = 1'b0;
        case (state_q)
`ifdef DISP_SCAN_BLANK_EN
            P0_BLANK: if (cnt_q == BLANK_LAST) state_d = P0_SHOW;
            P0_SHOW: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = P1_BLANK;
                    cnt_d   = '0;
                end
            end
            P1_BLANK: if (cnt_q == BLANK_LAST) state_d = P1_SHOW;
            P1_SHOW: begin
                if (cnt_q == CNT_LAST) begin
                    state_d    = P0_BLANK;
                    cnt_d      = '0;
                    frame_edge = 1'b1;
                end
            end
            default: begin
                state_d = RESET_STATE;
                cnt_d   = '0;
            end
`else
            P0_SHOW: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = P1_SHOW;
                    cnt_d   = '0;
                end
            end
            P1_SHOW: begin
                if (cnt_q == CNT_LAST) begin
                    state_d    = P0_SHOW;
                    cnt_d      = '0;
                    frame_edge = 1'b1;
                end
            end
            default: begin
                state_d = RESET_STATE;
                cnt_d   = '0;
            end
`endif
        endcase
    end

    // Shadows reload only at frame boundaries (plus once after reset) so a frame never tears.
    always_comb begin
        init_d     = 1'b0;
        shadow_d   = shadow_q;
        mask_d     = mask_q;
        fcnt_d     = fcnt_q;
        blink_ph_d = blink_ph_q;
        if (init_q || frame_edge) begin
            shadow_d = {seg3, seg2, seg1, seg0};
            mask_d   = blink_mask;
        end
        if (frame_edge) begin
            if (fcnt_q == FRAME_LAST) begin
                fcnt_d     = '0;
                blink_ph_d = ~blink_ph_q;
            end else begin
                fcnt_d = fcnt_q + FW'(1);
            end
        end
    end

    always_comb begin
        code         = '0;
        sel_d        = (state_d == P1_BLANK) || (state_d == P1_SHOW);
        seg_a_d      = '0;
        seg_b_d      = '0;
        frame_tick_d = frame_edge;
        for (int i = 0; i < 4; i++) begin
            code[i] = (mask_d[i] && blink_ph_d) ? 7'h00 : shadow_d[i];
        end
        if (disp_en) begin
            case (state_d)
                P0_SHOW: begin
                    seg_a_d = code[0];
                    seg_b_d = code[2];
                end
                P1_SHOW: begin
                    seg_a_d = code[1];
                    seg_b_d = code[3];
                end
                default: begin
                    seg_a_d = '0;
                    seg_b_d = '0;
                end
            endcase
        end
    end

    assign sel        = sel_q;
    assign seg_a      = seg_a_q;
    assign seg_b      = seg_b_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl (REFRESH_DIV=8, BLANK_CYC=2, BLINK_FRAMES=2); follows DISP_SCAN_BLANK_EN.
module tb_display_scan_ctrl;

`ifdef DISP_SCAN_BLANK_EN
    localparam int NB = 2;
`else
    localparam int NB = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] seg0, seg1, seg2, seg3;
    logic [3:0] blink_mask;
    logic       disp_en;
    logic       sel;
    logic [6:0] seg_a, seg_b;
    logic       frame_tick;

    int checks = 0;
    int passed = 0;
    int p      = 0;
    bit fresh  = 1'b1;

    display_scan_ctrl #(
        .REFRESH_DIV (8),
        .BLANK_CYC   (2),
        .BLINK_FRAMES(2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .seg0      (seg0),
        .seg1      (seg1),
        .seg2      (seg2),
        .seg3      (seg3),
        .blink_mask(blink_mask),
        .disp_en   (disp_en),
        .sel       (sel),
        .seg_a     (seg_a),
        .seg_b     (seg_b),
        .frame_tick(frame_tick)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s p=%0d got %h want %h", tag, p, obs, exp);
    endtask

    task automatic chk_dark(input string tag);
        chk({tag, "_sel"}, {6'b0, sel}, 7'h00);
        chk({tag, "_seg_a"}, seg_a, 7'h00);
        chk({tag, "_seg_b"}, seg_b, 7'h00);
        chk({tag, "_tick"}, {6'b0, frame_tick}, 7'h00);
    endtask

    // One cycle: p is the position within the 16-cycle frame; e0..e3 are the digit values
    // expected on the buses this frame (already blanked where blink applies).
    task automatic step_chk(input logic [6:0] e0, input logic [6:0] e1,
                            input logic [6:0] e2, input logic [6:0] e3);
        logic       ph1, dark, tick;
        logic [6:0] ea, eb;
        @(negedge clk);
        p = (p + 1) % 16;
        if (p == 0) fresh = 1'b0;
        ph1  = (p >= 8);
        dark = ((p % 8) < NB) || !disp_en;
        tick = (p == 0) && !fresh;
        ea   = dark ? 7'h00 : (ph1 ? e1 : e0);
        eb   = dark ? 7'h00 : (ph1 ? e3 : e2);
        chk("sel", {6'b0, sel}, {6'b0, ph1});
        chk("seg_a", seg_a, ea);
        chk("seg_b", seg_b, eb);
        chk("frame_tick", {6'b0, frame_tick}, {6'b0, tick});
    endtask

    task automatic run(input int n, input logic [6:0] e0, input logic [6:0] e1,
                       input logic [6:0] e2, input logic [6:0] e3);
        repeat (n) step_chk(e0, e1, e2, e3);
    endtask

    initial begin
        seg0 = 7'h06; seg1 = 7'h5B; seg2 = 7'h4F; seg3 = 7'h66;
        blink_mask = 4'b0000;
        disp_en    = 1'b1;

        repeat (3) begin
            @(negedge clk);
            chk_dark("reset_hold");
        end
        rst = 1'b0; p = 0; fresh = 1'b1;

        // frame 0 (reset cycle was p=0), frame 1 with seg1 changed after p=5
        run(15, 7'h06, 7'h5B, 7'h4F, 7'h66);
        run(6, 7'h06, 7'h5B, 7'h4F, 7'h66);
        seg1 = 7'h7F;
        run(10, 7'h06, 7'h5B, 7'h4F, 7'h66);
        run(16, 7'h06, 7'h7F, 7'h4F, 7'h66);

        // blink_ph is 1 in frames 2,3,6,7; the mask takes effect from frame 3
        blink_mask = 4'b0001;
        run(16, 7'h00, 7'h7F, 7'h4F, 7'h66);
        run(32, 7'h06, 7'h7F, 7'h4F, 7'h66);
        run(32, 7'h00, 7'h7F, 7'h4F, 7'h66);

        blink_mask = 4'b0000;
        disp_en    = 1'b0;
        run(20, 7'h06, 7'h7F, 7'h4F, 7'h66);
        disp_en    = 1'b1;
        run(8, 7'h06, 7'h7F, 7'h4F, 7'h66);

        // now at p=11, inside P1_SHOW
        rst = 1'b1;
        #1;
        chk_dark("midreset_async");
        @(negedge clk);
        chk_dark("midreset_hold");
        rst = 1'b0; p = 0; fresh = 1'b1;

        run(15, 7'h06, 7'h7F, 7'h4F, 7'h66);
        run(16, 7'h06, 7'h7F, 7'h4F, 7'h66);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/display_scan_ctrl.md
# display_scan_ctrl

Time-multiplexing scheduler for the door-lock's two shared 7-segment buses. It takes the four per-digit segment codes and drives them onto bus A (digits 0/1) and bus B (digits 2/3) in alternating phases, with a shared select line. Each phase starts with an anti-ghosting blank interval, and per-digit blinking is applied for edit feedback. It sits between `sseg` and the board pins, replacing the free-running select toggle in the top level.

## Interface
- `REFRESH_DIV`, 8192: cycles per phase (blank + show); must be ≥ 2
- `BLANK_CYC`, 64: blank cycles at the start of each phase; must be < `REFRESH_DIV`
- `BLINK_FRAMES`, 32: frames per blink half-period; must be ≥ 1
- `clk` in 1: system clock, all logic on rising edge
- `rst` in 1: asynchronous, active-high reset
- `seg0`..`seg3` in 7 each: active-high segment codes for digits 0–3
- `blink_mask` in 4: bit i set means digit i blinks
- `disp_en` in 1: 0 forces both buses dark; scheduling continues
- `sel` out 1: 0 while showing digits 0/2, 1 while showing digits 1/3; drives both select pins
- `seg_a` out 7: bus A (digit 0 when `sel`=0, digit 1 when `sel`=1)
- `seg_b` out 7: bus B (digit 2 when `sel`=0, digit 3 when `sel`=1)
- `frame_tick` out 1: one-cycle pulse in the first cycle of each frame after the first

## Operation
- FSM states: `P0_BLANK` → `P0_SHOW` → `P1_BLANK` → `P1_SHOW` → `P0_BLANK`.
- Phase counter `cnt` runs 0..`REFRESH_DIV`-1 and is cleared on every phase change.
- BLANK → SHOW of the same phase when `cnt` = `BLANK_CYC`-1.
- SHOW → next phase BLANK when `cnt` = `REFRESH_DIV`-1.
- `sel` is 0 in the P0 states and 1 in the P1 states.
- In BLANK states, `seg_a` = `seg_b` = 7'h00.
- Shadow registers hold `seg0..3` and `blink_mask`. They load on every `P1_SHOW`→`P0_BLANK` edge and on the first clock edge after reset release. The displayed frame therefore never tears mid-frame.
- Blink counter: frame count increments on each `P1_SHOW`→`P0_BLANK` edge. On wrap at `BLINK_FRAMES`-1 it clears and `blink_ph` toggles.
- Digit i displays 7'h00 if shadow mask bit i = 1 and `blink_ph` = 1. Otherwise it displays its shadow code.
- `disp_en` = 0 forces `seg_a`/`seg_b` to 7'h00 from the next edge. The FSM, `sel`, blink and shadow logic are unaffected.
- Outputs are registered from next-state logic, so `sel`/`seg_a`/`seg_b` change on the same edge as the state.

## Timing
- Reset values: state `P0_BLANK`, `cnt` 0, `sel` 0, `seg_a` 0, `seg_b` 0, `frame_tick` 0, `blink_ph` 0, frame count 0, shadows 0.
- Reset mid-frame returns to the reset values immediately, with no completion of the current phase.
- Frame length is exactly 2×`REFRESH_DIV` cycles.
- Show window is `REFRESH_DIV`-`BLANK_CYC` cycles per phase.
- Input change to visible: at most one frame plus 1 cycle (next shadow load).
- `frame_tick` is high in the same cycle the state first reads `P0_BLANK` of a new frame.
- Simultaneous blink wrap and shadow load: the new mask is combined with the new `blink_ph` from the next cycle.
- Counter width: $clog2(`REFRESH_DIV`). No overflow is possible, because the wrap compare precedes the increment.

## Configuration
- `DISP_SCAN_BLANK_EN` defined: blank states are present as described.
- `DISP_SCAN_BLANK_EN` undefined:
  - `BLANK_CYC` is ignored and the BLANK states are removed.
  - Each phase is `REFRESH_DIV` cycles of SHOW, and `sel` toggles directly between SHOW states.
  - Shadow load and `frame_tick` occur on the `P1_SHOW`→`P0_SHOW` edge.

## Test plan
Test parameters: `REFRESH_DIV`=8, `BLANK_CYC`=2, `BLINK_FRAMES`=2, macro defined unless stated.

- **Reset check.** Hold `rst` 3 cycles with inputs nonzero → `sel`=0, `seg_a`=`seg_b`=0, `frame_tick`=0 throughout. After release, 2 blank cycles, then `seg_a`=`seg0`, `seg_b`=`seg2` for 6 cycles.
- **Scan order.** Set `seg0..3` = 7'h06/5B/4F/66 → repeating 16-cycle pattern: 2 blank, 6×(06,4F) with `sel`=0, 2 blank, 6×(5B,66) with `sel`=1. `frame_tick` pulses every 16 cycles.
- **No tearing.** Change `seg1` to 7'h7F in cycle 5 of a frame → current frame still shows old `seg1`; next frame shows 7'h7F.
- **Blink.** `blink_mask`=4'b0001 → digit 0 shows 7'h06 for 2 frames, then 7'h00 for 2 frames, repeating. Other digits are steady.
- **Enable gating and mid-frame reset.** `disp_en`=0 for 20 cycles → buses 0 while `sel` keeps toggling every 8 cycles. Then assert `rst` in a `P1_SHOW` cycle → next sample shows `sel`=0 and buses 0.
- **Macro undefined.** Same stimulus as scan order → no blank cycles. `sel` toggles every 8 cycles and buses are always non-zero.
